// File: rtl/m8_checker.sv
// Telemetry frame checker: hunts for frame sync, verifies counter fields and tracks lock/loss.
// Optional macro M8CHK_FILLER_CHECK_EN enables comparison of filler words against 12'h002.
`timescale 1ns/1ps

module m8_checker #(
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned LOSS_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wordValid,
    input  logic [9:0]  wordIdx,
    input  logic [4:0]  numGrp,
    input  logic [11:0] dataWord,
    output logic        locked,
    output logic        errFlag,
    output logic [15:0] errCnt,
    output logic [15:0] frameCnt,
    output logic [9:0]  lastErrIdx
);

    localparam int unsigned FW = 10;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t         state;
    logic [FW-1:0]  fa_ref;
    logic [FW-1:0]  fb_ref;
    logic [FW-1:0]  fs_ref;
    logic [4:0]     fb_grp;
    logic           fb_valid;
    logic           fs_valid;
    logic [CW-1:0]  clean_cnt;
    logic [CW-1:0]  loss_cnt;
    logic           frame_err;

    logic           is_a;
    logic           is_b;
    logic           is_s;
    logic           fb_step;
    logic [FW-1:0]  fa_exp;
    logic [FW-1:0]  fb_exp;
    logic [FW-1:0]  fs_exp;
    logic           bad_c;

    // Word classification and expected-value decode for the word on the bus
    always_comb begin
        is_a    = (wordIdx == 10'd0);
        is_b    = (wordIdx == 10'd1);
        is_s    = (wordIdx[5:0] == 6'd6);
        fb_step = (fb_grp == 5'd1) || (fb_grp == 5'd9) ||
                  (fb_grp == 5'd17) || (fb_grp == 5'd25);
        fa_exp  = FW'(fa_ref + 10'd1);
        fb_exp  = FW'(fb_ref + {9'd0, fb_step});
        fs_exp  = FW'(fs_ref + 10'd1);
        bad_c   = 1'b0;
        if (is_a) begin
            bad_c = (dataWord[1:0] != 2'b01) || (dataWord[11:2] != fa_exp);
        end else if (is_b) begin
            bad_c = dataWord[11] || !dataWord[0] ||
                    (fb_valid && (dataWord[10:1] != fb_exp));
        end else if (is_s) begin
            bad_c = dataWord[11] || dataWord[0] ||
                    (fs_valid && (dataWord[10:1] != fs_exp));
        end else begin
`ifdef M8CHK_FILLER_CHECK_EN
            bad_c = (dataWord != 12'h002);
`else
            bad_c = 1'b0;
`endif
        end
    end

    // Sync state machine; references always follow received fields so one glitch costs one error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            fa_ref     <= '0;
            fb_ref     <= '0;
            fs_ref     <= '0;
            fb_grp     <= '0;
            fb_valid   <= 1'b0;
            fs_valid   <= 1'b0;
            clean_cnt  <= '0;
            loss_cnt   <= '0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
            errFlag    <= 1'b0;
            errCnt     <= '0;
            frameCnt   <= '0;
            lastErrIdx <= '0;
        end else begin
            errFlag <= 1'b0;
            if (wordValid) begin
                if (is_a) begin
                    frameCnt <= frameCnt + 16'd1;
                end
                if (state == HUNT) begin
                    if (is_a) begin
                        fa_ref    <= dataWord[11:2];
                        fb_valid  <= 1'b0;
                        fs_valid  <= 1'b0;
                        clean_cnt <= '0;
                        loss_cnt  <= '0;
                        frame_err <= 1'b0;
                        state     <= VERIFY;
                    end
                end else begin
                    if (is_a) begin
                        fa_ref <= dataWord[11:2];
                    end else if (is_b) begin
                        fb_ref   <= dataWord[10:1];
                        fb_grp   <= numGrp;
                        fb_valid <= 1'b1;
                    end else if (is_s) begin
                        fs_ref   <= dataWord[10:1];
                        fs_valid <= 1'b1;
                    end
                    if (bad_c) begin
                        errFlag    <= 1'b1;
                        lastErrIdx <= wordIdx;
                    end

                    if (state == VERIFY) begin
                        if (bad_c) begin
                            state <= HUNT;
                        end else if (is_a) begin
                            if (clean_cnt == CW'(LOCK_FRAMES - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                loss_cnt  <= '0;
                                frame_err <= 1'b0;
                            end else begin
                                clean_cnt <= clean_cnt + 4'd1;
                            end
                        end
                    end else begin
                        if (bad_c && (errCnt != 16'hFFFF)) begin
                            errCnt <= errCnt + 16'd1;
                        end
                        // An A-word closes the running frame and opens the next one
                        if (is_a) begin
                            frame_err <= bad_c;
                            if (frame_err) begin
                                if (loss_cnt == CW'(LOSS_FRAMES - 1)) begin
                                    state     <= HUNT;
                                    locked    <= 1'b0;
                                    loss_cnt  <= '0;
                                    clean_cnt <= '0;
                                end else begin
                                    loss_cnt <= loss_cnt + 4'd1;
                                end
                            end else begin
                                loss_cnt <= '0;
                            end
                        end else if (bad_c) begin
                            frame_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/m8_checker.md
M8_CHECKER -- requirements
Module: m8_checker

Interface
REQ-001 LOCK_FRAMES, 4, consecutive clean frames needed to go from VERIFY to LOCKED (range 1..15).
REQ-002 LOSS_FRAMES, 3, consecutive errored frames needed to drop from LOCKED to HUNT (range 1..15).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 wordValid  in  1  one-cycle strobe; the word fields are valid in this cycle.
REQ-006 wordIdx  in  10  position of the word within the frame (0..1023).
REQ-007 numGrp  in  5  group number of the current frame.
REQ-008 dataWord  in  12  received telemetry word.
REQ-009 locked  out  1  high while state is LOCKED.
REQ-010 errFlag  out  1  one-cycle pulse for each mismatched word.
REQ-011 errCnt  out  16  mismatched words counted while LOCKED; saturates at 16'hFFFF.
REQ-012 frameCnt  out  16  idx-0 words received; wraps around.
REQ-013 lastErrIdx  out  10  wordIdx of the most recent mismatch.

Function
REQ-014 All state updates shall occur only on cycles with wordValid=1; every other cycle shall hold state, except that errFlag returns to 0.
REQ-015 Word classes shall be:
- A: idx 0.
- B: idx 1.
- S: idx[5:0]=6.
- F: all other indices.
REQ-016 A-word expected format:
- dataWord[1:0]=2'b01.
- Field FA=dataWord[11:2] shall equal the previous FA+1 mod 1024.
REQ-017 B-word expected format:
- dataWord[11]=0 and dataWord[0]=1.
- Field FB=dataWord[10:1] shall equal the previous FB+1 when the previous B-word's numGrp was in {1,9,17,25}; otherwise it shall equal the previous FB.
REQ-018 S-word expected format:
- dataWord[11]=0 and dataWord[0]=0.
- Field FS=dataWord[10:1] shall equal the previous FS+1 mod 1024, counted across consecutive S-words.
REQ-019 F-word expected value: exactly 12'h002.
REQ-020 All expected-value arithmetic shall be 10-bit and wrap (1023+1 -> 0 is not an error).
REQ-021 States shall be HUNT, VERIFY and LOCKED; the reset state is HUNT.
REQ-022 HUNT behaviour:
- No words are checked.
- On an A-word, load the FA/FB/FS references from the incoming fields (FB and FS load on their first occurrence) and go to VERIFY.
REQ-023 VERIFY behaviour:
- Words are checked.
- A frame is clean when no mismatch occurs between two A-words.
- After LOCK_FRAMES consecutive clean frames, go to LOCKED.
- Any mismatch returns the state to HUNT.
REQ-024 LOCKED behaviour:
- Each mismatch increments errCnt and marks the frame errored.
- After LOSS_FRAMES consecutive errored frames, go to HUNT.
- A clean frame clears the consecutive-error count.
REQ-025 On a counter-field mismatch, the reference shall resync to the received value, so a single glitch costs one error, not a cascade.
REQ-026 errFlag and lastErrIdx shall update in the cycle after the wordValid strobe (1-cycle latency) in VERIFY and LOCKED; no errors are flagged in HUNT.
REQ-027 An A-word arriving while a frame is still open shall close that frame (evaluate clean/errored) and open the next frame in the same cycle.
REQ-028 An A-word shall increment frameCnt in every state.
REQ-029 A repeated wordIdx is checked normally; there shall be no duplicate detection.

Reset
REQ-030 On reset low, all outputs shall go to 0 immediately (locked, errFlag, errCnt, frameCnt, lastErrIdx), the state shall go to HUNT, and all references and frame counters shall clear.
REQ-031 Reset asserted mid-frame shall discard that partial frame; after release, checking resumes only from the next A-word.

Configuration
REQ-032 Macro M8CHK_FILLER_CHECK_EN selects F-word checking:
- Defined: F-words are compared against 12'h002 per REQ-019.
- Undefined: F-words are never counted as errors; only A, B and S words are checked.

Verification
REQ-033 Reset released; then 6 clean frames, FA=0..5, default parameters -> locked=1 after the A-word of frame 4 (FA=4); errCnt=0; frameCnt=6.
REQ-034 Locked stream; the F-word at idx 300 is 12'h0A5 -> errFlag pulses once, lastErrIdx=300, errCnt=1, locked stays 1 (filler check enabled); with the macro undefined -> no pulse, errCnt=0.
REQ-035 Locked stream; FA jumps 7 -> 20, then continues 21, 22, ... -> exactly one error (errCnt=1), the reference resyncs, and locked stays 1.
REQ-036 Locked stream; the S-word at idx 70 is corrupted in 3 consecutive frames -> locked falls to 0 at the A-word after the third errored frame, and the state is HUNT.
REQ-037 FA wraps 1022, 1023, 0, 1; numGrp cycles 0..31 with FB stepping only after groups 1/9/17/25 -> no errors.
REQ-038 Reset pulled low in the middle of a frame (idx 500) -> all outputs 0 asynchronously, and the next A-word after release restarts HUNT -> VERIFY.
